serial_ripple_subtractor: RTL
=============================

SERIAL_RIPPLE_SUBTRACTOR -- requirements
Module: serial_ripple_subtractor

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter WIDTH, default 8, SHALL set the operand width in bits; legal range is 2 to 32.
REQ-003 Port clk SHALL be an input, 1 bit wide: the rising-edge clock.
REQ-004 Port rst SHALL be an input, 1 bit wide: synchronous, active-high reset.
REQ-005 Port in_valid SHALL be an input, 1 bit wide: the operand pair is valid.
REQ-006 Port in_ready SHALL be an output, 1 bit wide: the block can accept an operand pair.
REQ-007 Port a SHALL be an input, WIDTH bits wide: the minuend.
REQ-008 Port b SHALL be an input, WIDTH bits wide: the subtrahend.
REQ-009 Port out_valid SHALL be an output, 1 bit wide: the result is valid.
REQ-010 Port out_ready SHALL be an input, 1 bit wide: downstream accepts the result.
REQ-011 Port diff SHALL be an output, WIDTH bits wide: a-b modulo 2^WIDTH.
REQ-012 Port b_out SHALL be an output, 1 bit wide: borrow out, 1 when a<b (unsigned).
REQ-013 Port busy SHALL be an output, 1 bit wide: high in the RUN and DONE states.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 IDLE: in_ready=1; on in_valid&&in_ready the block SHALL capture a and b, clear the borrow register, set the bit index to 0 and go to RUN.
REQ-016 in_ready SHALL be 0 in RUN and DONE; in_valid in those states SHALL be ignored and the operands SHALL NOT be captured.
REQ-017 RUN: each cycle SHALL process bit i, LSB first.
  - d_i = a_i ^ b_i ^ bw
  - bw_next = (~a_i & b_i) | (~(a_i ^ b_i) & bw)
  - d_i is shifted into the result register at position i.
REQ-018 RUN SHALL last exactly WIDTH cycles; after the cycle that processes bit WIDTH-1, the block SHALL go to DONE.
REQ-019 DONE: out_valid=1; diff holds the full result and b_out holds the final borrow.
REQ-020 In DONE, diff and b_out SHALL be held stable while out_ready=0.
REQ-021 On out_valid&&out_ready the block SHALL go to IDLE; a new operand SHALL NOT be accepted in that same cycle.
REQ-022 Latency SHALL be WIDTH+1 cycles from the accepting edge to the first cycle with out_valid=1.
REQ-023 Minimum initiation interval SHALL be WIDTH+2 cycles.
REQ-024 The result SHALL equal the WIDTH-bit two's-complement difference; b_out SHALL equal the inverted carry of a+~b+1.
REQ-025 diff SHALL hold its last completed value outside DONE (it is undefined to consumers, but deterministic); out_valid SHALL be 0 outside DONE.

Reset
REQ-026 With rst=1 at a rising edge, the block SHALL enter IDLE.
  - Outputs on the next cycle: out_valid=0, diff=0, b_out=0, busy=0, in_ready=1.
  - Internal operand, borrow and index registers SHALL be cleared.
REQ-027 Reset asserted during RUN or DONE SHALL abort the operation; the partial result SHALL be discarded and never presented.
REQ-028 Reset SHALL take priority over every handshake event in the same cycle.

Structure
REQ-029 A shared package SHALL hold:
  - the FSM state enum (IDLE, RUN, DONE);
  - the default WIDTH constant;
  - the index width, computed as $clog2(WIDTH).
REQ-030 The per-bit logic SHALL be a combinational sub-module named full_subtractor, with inputs x, y, bin and outputs d, bout.
REQ-031 The block SHALL instantiate full_subtractor exactly once and reuse it every cycle.

Verification
REQ-032 Scenario: a=0x05, b=0x03 -> diff=0x02, b_out=0, out_valid rises 9 cycles after accept.
REQ-033 Scenario: a=0x03, b=0x05 -> diff=0xFE, b_out=1; and a=0x00, b=0x01 -> diff=0xFF, b_out=1.
REQ-034 Scenario: a=0xFF, b=0xFF -> diff=0x00, b_out=0; and a=0x80, b=0x7F -> diff=0x01, b_out=0.
REQ-035 Scenario: out_ready held 0 for 5 cycles in DONE -> diff, b_out and out_valid stable throughout; in_ready=0; in_valid pulses ignored.
REQ-036 Scenario: rst pulsed on the 4th RUN cycle -> next cycle IDLE, out_valid=0, diff=0; a following a=0x10, b=0x01 yields 0x0F, b_out=0.
REQ-037 Scenario: back-to-back transfers with in_valid and out_ready held high -> accepts spaced exactly WIDTH+2 cycles apart; 256 random pairs match a-b with the correct borrow.

Source files
------------

// File: rtl/serial_ripple_subtractor_pkg.sv
// Shared types and constants for the bit-serial ripple subtractor.
package serial_ripple_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int idx_width(input int width);
    return $clog2(width);
  endfunction

  localparam int DEFAULT_IDX_W = idx_width(DEFAULT_WIDTH);

endpackage

// File: rtl/serial_ripple_subtractor_full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, bout is the borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial a-b, LSB first, one shared full subtractor, valid/ready on both sides.
// state | meaning
// IDLE  | waiting for an operand pair (in_ready=1)
// RUN   | processing one bit per cycle, WIDTH cycles
// DONE  | result presented (out_valid=1) until out_ready
module serial_ripple_subtractor
  import serial_ripple_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             busy
);

  localparam int IW = idx_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bw_q, bw_d;
  logic             b_out_q, b_out_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             fs_d, fs_bout;

  full_subtractor u_fs (
    .x    (a_q[idx_q]),
    .y    (b_q[idx_q]),
    .bin  (bw_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    diff_d  = diff_q;
    bw_d    = bw_q;
    b_out_d = b_out_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          bw_d    = 1'b0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d[idx_q] = fs_d;
        bw_d         = fs_bout;
        idx_d        = idx_q + IW'(1);
        // diff only changes on completion so a partial result is never visible
        if (idx_q == IW'(WIDTH - 1)) begin
          diff_d  = acc_d;
          b_out_d = fs_bout;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      diff_q      <= '0;
      bw_q        <= 1'b0;
      b_out_q     <= 1'b0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      diff_q      <= diff_d;
      bw_q        <= bw_d;
      b_out_q     <= b_out_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign b_out     = b_out_q;
  assign busy      = busy_q;

endmodule
